// File: rtl/wb_stage.sv
// wb_stage: writeback stage selecting ALU/load/link results, aligning late load
// data and driving the single register-file write port plus hazard outputs.
module wb_stage #(
  parameter int ADDR_WIDTH = 5,
  parameter int DATA_WIDTH = 32
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic                  in_wen,
  input  logic [ADDR_WIDTH-1:0] in_rd_sel,
  input  logic [1:0]            in_src_sel,
  input  logic [DATA_WIDTH-1:0] in_alu_result,
  input  logic [DATA_WIDTH-1:0] in_pc_plus4,
  input  logic [2:0]            in_funct3,
  input  logic                  mem_rvalid,
  input  logic [DATA_WIDTH-1:0] mem_rdata,
  output logic                  wen,
  output logic [ADDR_WIDTH-1:0] rd_sel,
  output logic [DATA_WIDTH-1:0] wb_data,
  output logic                  fwd_valid,
  output logic                  pend_valid,
  output logic [ADDR_WIDTH-1:0] pend_rd_sel
);
  typedef enum logic [1:0] {IDLE, WAIT_MEM, WRITE} state_t;
  state_t                state_q, state_d;
  logic [ADDR_WIDTH-1:0] rd_q, rd_d;
  logic                  cap_wen_q, cap_wen_d;
  logic [2:0]            funct3_q, funct3_d;
  logic [1:0]            off_q, off_d;
  logic [DATA_WIDTH-1:0] data_q, data_d, load_fmt;
  logic [7:0]            ld_byte;
  logic [15:0]           ld_half;
  logic                  accept, dst_live;
  assign in_ready = state_q != WAIT_MEM;
  assign accept   = in_valid & in_ready;
  assign dst_live = cap_wen_q & (rd_q != '0);
  always_comb begin
    ld_byte  = 8'(mem_rdata >> {off_q, 3'b000});
    ld_half  = off_q[1] ? mem_rdata[31:16] : mem_rdata[15:0];
    load_fmt = (funct3_q == 3'b000) ? {{(DATA_WIDTH-8){ld_byte[7]}}, ld_byte} :
               (funct3_q == 3'b100) ? {{(DATA_WIDTH-8){1'b0}}, ld_byte} :
               (funct3_q == 3'b001) ? {{(DATA_WIDTH-16){ld_half[15]}}, ld_half} :
               (funct3_q == 3'b101) ? {{(DATA_WIDTH-16){1'b0}}, ld_half} : mem_rdata;
  end
  always_comb begin
    state_d   = state_q;
    rd_d      = rd_q;
    cap_wen_d = cap_wen_q;
    funct3_d  = funct3_q;
    off_d     = off_q;
    data_d    = data_q;
    if (accept) begin
      rd_d      = in_rd_sel;
      cap_wen_d = in_wen;
      if (in_src_sel == 2'b01) begin
        state_d  = WAIT_MEM;
        funct3_d = in_funct3;
        off_d    = in_alu_result[1:0];
      end else begin
        state_d = WRITE;
        data_d  = (in_src_sel == 2'b10) ? in_pc_plus4 : in_alu_result;
      end
    end else if (state_q == WAIT_MEM) begin
      state_d = mem_rvalid ? WRITE : WAIT_MEM;
      data_d  = mem_rvalid ? load_fmt : data_q;
    end else if (state_q == WRITE) begin
      state_d = IDLE;
    end
  end
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q   <= IDLE;
      rd_q      <= '0;
      cap_wen_q <= 1'b0;
      funct3_q  <= '0;
      off_q     <= '0;
      data_q    <= '0;
    end else begin
      state_q   <= state_d;
      rd_q      <= rd_d;
      cap_wen_q <= cap_wen_d;
      funct3_q  <= funct3_d;
      off_q     <= off_d;
      data_q    <= data_d;
    end
  end
  assign wen         = (state_q == WRITE) & dst_live;
  assign fwd_valid   = wen;
  assign rd_sel      = rd_q;
  assign wb_data     = data_q;
  assign pend_valid  = (state_q == WAIT_MEM) & dst_live;
  assign pend_rd_sel = rd_q;
endmodule

// File: tb/tb_wb_stage.sv
// tb_wb_stage: scoreboard bench for wb_stage with a behavioural load model.
module tb_wb_stage;
  logic        clk = 0, reset = 1;
  logic        in_valid = 0, in_ready, in_wen = 0;
  logic [4:0]  in_rd_sel = 0;
  logic [1:0]  in_src_sel = 0;
  logic [31:0] in_alu_result = 0, in_pc_plus4 = 0, mem_rdata = 0;
  logic [2:0]  in_funct3 = 0;
  logic        mem_rvalid = 0;
  logic        wen, fwd_valid, pend_valid;
  logic [4:0]  rd_sel, pend_rd_sel;
  logic [31:0] wb_data;
  int          tests = 0, fails = 0;
  logic [36:0] exp_q[$];
  logic [31:0] rf_exp[32], rf_dut[32];
  logic        ld_wen;
  logic [4:0]  ld_rd;
  logic [2:0]  ld_f3;
  logic [1:0]  ld_off;

  wb_stage dut (
    .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(in_ready),
    .in_wen(in_wen), .in_rd_sel(in_rd_sel), .in_src_sel(in_src_sel),
    .in_alu_result(in_alu_result), .in_pc_plus4(in_pc_plus4), .in_funct3(in_funct3),
    .mem_rvalid(mem_rvalid), .mem_rdata(mem_rdata), .wen(wen), .rd_sel(rd_sel),
    .wb_data(wb_data), .fwd_valid(fwd_valid), .pend_valid(pend_valid),
    .pend_rd_sel(pend_rd_sel)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  function automatic logic [31:0] load_model(input logic [2:0] f3, input logic [1:0] a, input logic [31:0] w);
    logic [31:0] v;
    if (f3 == 3'b000 || f3 == 3'b100) begin
      v = (w >> (8 * a)) & 32'hFF;
      if (f3 == 3'b000 && v >= 128) v = v - 256;
    end else if (f3 == 3'b001 || f3 == 3'b101) begin
      v = (w >> (16 * a[1])) & 32'hFFFF;
      if (f3 == 3'b001 && v >= 32768) v = v - 65536;
    end else v = w;
    return v;
  endfunction

  task automatic expect_write(input logic w, input logic [4:0] rd, input logic [31:0] d);
    if (w && rd != 0) begin
      exp_q.push_back({rd, d});
      rf_exp[rd] = d;
    end
  endtask

  task automatic tick();
    @(posedge clk); #1;
  endtask

  task automatic issue(input logic w, input logic [4:0] rd, input logic [1:0] src,
                       input logic [31:0] alu, input logic [31:0] pc, input logic [2:0] f3);
    int n = 0;
    while (!in_ready && n < 20) begin tick(); n++; end
    if (!in_ready) chk("ready_timeout", 32'(in_ready), 32'd1);
    in_valid = 1; in_wen = w; in_rd_sel = rd; in_src_sel = src;
    in_alu_result = alu; in_pc_plus4 = pc; in_funct3 = f3;
    if (src == 2'b01) begin
      ld_wen = w; ld_rd = rd; ld_f3 = f3; ld_off = alu[1:0];
    end else expect_write(w, rd, src == 2'b10 ? pc : alu);
    mem_rvalid = 1'($urandom_range(0, 1));
    mem_rdata = $urandom;
    tick();
    in_valid = 0; mem_rvalid = 0;
  endtask

  task automatic mem_resp(input int dly, input logic [31:0] w);
    for (int i = 1; i < dly; i++) begin
      chk("wait_ready", 32'(in_ready), 32'd0);
      chk("wait_pend", 32'(pend_valid), 32'(ld_wen && ld_rd != 0));
      chk("wait_pend_rd", 32'(pend_rd_sel), 32'(ld_rd));
      tick();
    end
    chk("wait_ready_last", 32'(in_ready), 32'd0);
    expect_write(ld_wen, ld_rd, load_model(ld_f3, ld_off, w));
    mem_rvalid = 1; mem_rdata = w;
    tick();
    mem_rvalid = 0;
  endtask

  always @(negedge clk) begin
    if (!reset) begin
      chk("fwd_eq_wen", 32'(fwd_valid), 32'(wen));
      if (wen) begin
        rf_dut[rd_sel] = wb_data;
        if (exp_q.size() == 0) chk("unexpected_write", {27'd0, rd_sel}, 32'd0);
        else begin
          logic [36:0] e;
          e = exp_q.pop_front();
          chk("sb_rd", 32'(rd_sel), 32'(e[36:32]));
          chk("sb_data", wb_data, e[31:0]);
        end
      end
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [31:0] ld_exp[6];
    logic [2:0]  ld_f3s[6];
    logic [1:0]  ld_offs[6];
    ld_exp  = '{32'hFFFF_FF80, 32'h0000_0080, 32'h0000_7F01, 32'hFFFF_80FF, 32'h0000_80FF, 32'h80FF_7F01};
    ld_f3s  = '{3'b000, 3'b100, 3'b001, 3'b001, 3'b101, 3'b010};
    ld_offs = '{2'd3, 2'd3, 2'd0, 2'd2, 2'd2, 2'd1};
    for (int i = 0; i < 32; i++) begin rf_exp[i] = 0; rf_dut[i] = 0; end
    repeat (3) tick();
    reset = 0;
    for (int i = 0; i < 5; i++) begin
      chk("rst_wen", 32'(wen), 32'd0);
      chk("rst_ready", 32'(in_ready), 32'd1);
      chk("rst_pend", 32'(pend_valid), 32'd0);
      chk("rst_rd_sel", 32'(rd_sel), 32'd0);
      chk("rst_pend_rd", 32'(pend_rd_sel), 32'd0);
      chk("rst_wb_data", wb_data, 32'd0);
      tick();
    end
    issue(1, 5, 2'b00, 32'h1234_5678, 0, 0);
    for (int r = 6; r <= 8; r++) begin
      chk("b2b_wen", 32'(wen), 32'd1);
      issue(1, 5'(r), 2'b00, 32'hA000_0000 + r, 0, 0);
    end
    chk("b2b_wen_last", 32'(wen), 32'd1);
    tick();
    chk("x5", rf_dut[5], 32'h1234_5678);
    for (int i = 0; i < 6; i++) begin
      issue(1, 10, 2'b01, 32'h0000_1000 | 32'(ld_offs[i]), 0, ld_f3s[i]);
      mem_resp(3, 32'h80FF_7F01);
      chk("ld_wen", 32'(wen), 32'd1);
      chk("ld_fmt", wb_data, ld_exp[i]);
      tick();
    end
    issue(1, 0, 2'b00, 32'hDEAD_BEEF, 0, 0);
    chk("x0_wen", 32'(wen), 32'd0);
    issue(0, 3, 2'b00, 32'h3333_3333, 0, 0);
    chk("nowen_wen", 32'(wen), 32'd0);
    tick();
    mem_rvalid = 1; mem_rdata = 32'h5555_5555;
    tick();
    mem_rvalid = 0;
    chk("idle_rvalid_ready", 32'(in_ready), 32'd1);
    chk("idle_rvalid_wen", 32'(wen), 32'd0);
    chk("idle_rvalid_pend", 32'(pend_valid), 32'd0);
    issue(1, 1, 2'b10, 32'hFFFF_0000, 32'h0000_0104, 0);
    chk("jal_wen", 32'(wen), 32'd1);
    chk("jal_rd", 32'(rd_sel), 32'd1);
    chk("jal_data", wb_data, 32'h0000_0104);
    tick();
    issue(1, 4, 2'b01, 32'h0000_2000, 0, 3'b010);
    chk("rstld_pend", 32'(pend_valid), 32'd1);
    reset = 1; mem_rvalid = 1; mem_rdata = 32'h4444_4444;
    tick();
    reset = 0; mem_rvalid = 0;
    chk("rstld_wen", 32'(wen), 32'd0);
    chk("rstld_ready", 32'(in_ready), 32'd1);
    chk("rstld_pend_after", 32'(pend_valid), 32'd0);
    tick();
    chk("rstld_wen2", 32'(wen), 32'd0);
    for (int i = 0; i < 60; i++) begin
      logic [1:0] src;
      src = 2'($urandom_range(0, 3));
      issue(1'($urandom_range(0, 4) != 0), 5'($urandom), src, $urandom, $urandom, 3'($urandom));
      if (src == 2'b01) mem_resp($urandom_range(1, 4), $urandom);
      if ($urandom_range(0, 3) == 0) tick();
    end
    repeat (3) tick();
    chk("sb_empty", 32'(exp_q.size()), 32'd0);
    for (int i = 0; i < 32; i++) chk($sformatf("rf_x%0d", i), rf_dut[i], rf_exp[i]);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule

// File: doc/wb_stage.md
# wb_stage

Writeback stage of the RISC-V pipeline, sitting directly upstream of the register file and driving its single write port. It accepts one retiring instruction per cycle from the memory stage and selects the result source (ALU, load data or PC+4). It waits for late load data from the data memory, aligns and extends that data, and then issues exactly one register-file write. It also exports forwarding and pending-destination information for the hazard logic.

## Interface
- ADDR_WIDTH, 5, register index width
- DATA_WIDTH, 32, datapath width
- CLK  in  1  clock, all state updates on rising edge
- RESET  in  1  synchronous, active-high reset
- IN_VALID  in  1  upstream instruction valid
- IN_READY  out  1  stage can accept; transfer when IN_VALID & IN_READY at a rising edge
- IN_WEN  in  1  instruction writes a destination register
- IN_RD_SEL  in  ADDR_WIDTH  destination register index
- IN_SRC_SEL  in  2  result source: 00 ALU, 01 load, 10 PC+4, 11 reserved (treated as ALU)
- IN_ALU_RESULT  in  DATA_WIDTH  ALU result; for loads, the effective address
- IN_PC_PLUS4  in  DATA_WIDTH  link value for JAL/JALR
- IN_FUNCT3  in  3  load type: 000 LB, 001 LH, 010 LW, 100 LBU, 101 LHU
- MEM_RVALID  in  1  load data valid from data memory
- MEM_RDATA  in  DATA_WIDTH  raw 32-bit word read from data memory
- WEN  out  1  register-file write enable
- RD_SEL  out  ADDR_WIDTH  register-file write index
- WB_DATA  out  DATA_WIDTH  register-file write data
- FWD_VALID  out  1  equal to WEN; WB_DATA is forwardable to RD_SEL
- PEND_VALID  out  1  a load is waiting for data
- PEND_RD_SEL  out  ADDR_WIDTH  destination register of the waiting load

## Operation
- States: IDLE, WAIT_MEM, WRITE.
- IN_READY is 1 in IDLE and WRITE, and 0 in WAIT_MEM. It is combinational from the state only.
- Accept with IN_SRC_SEL ≠ 01:
  - The result is captured: ALU result, or PC+4 when IN_SRC_SEL = 10.
  - Next state is WRITE.
- Accept with IN_SRC_SEL = 01:
  - The stage captures rd, funct3 and IN_ALU_RESULT[1:0].
  - Next state is WAIT_MEM.
- WAIT_MEM:
  - On MEM_RVALID = 1 the stage captures the formatted MEM_RDATA and moves to WRITE.
  - Otherwise it stays in WAIT_MEM indefinitely.
- WRITE with no new accept: next state is IDLE. A new accept in WRITE follows the accept rules above.
- IDLE with no accept: the stage stays in IDLE.
- Load formatting uses byte offset b = ADDR[1:0]:
  - LB: byte b, sign-extended from bit 7.
  - LBU: byte b, zero-extended.
  - LH: halfword ADDR[1] (bits 15:0 or 31:16), sign-extended. ADDR[0] is ignored.
  - LHU: same halfword selection, zero-extended.
  - LW, and the unlisted codes 011, 110 and 111: the full word, unmodified.
- WEN = (state == WRITE) & captured IN_WEN & (captured rd ≠ 0). A write to x0 never asserts WEN.
- RD_SEL and WB_DATA hold their last captured values whenever WEN = 0.
- PEND_VALID = (state == WAIT_MEM) & captured IN_WEN & (rd ≠ 0). PEND_RD_SEL = captured rd.
- MEM_RVALID is ignored in IDLE and WRITE, including in the cycle a load is accepted.

## Timing
- Reset values: state IDLE, IN_READY = 1, WEN = 0, FWD_VALID = 0, PEND_VALID = 0, RD_SEL = 0, PEND_RD_SEL = 0, WB_DATA = 0.
- Non-load latency: accept at edge N → WEN high during cycle N..N+1. The register file commits at edge N+1.
- Load latency: MEM_RVALID sampled at edge M → WEN high during cycle M..M+1.
  - The minimum is 2 cycles from accept to WEN, since the earliest usable MEM_RVALID is sampled one edge after accept.
- Throughput: one non-load per cycle; back-to-back accepts in WRITE give continuous WEN.
- A load stalls upstream (IN_READY = 0) for every cycle spent in WAIT_MEM.
- All outputs except IN_READY are registered or decoded from registered state. No combinational path runs from the IN_* or MEM_* inputs to WEN, RD_SEL or WB_DATA.
- Reset mid-operation:
  - RESET in WAIT_MEM discards the load; no write occurs, even if MEM_RVALID is high in the same cycle.
  - RESET in WRITE deasserts WEN from the next cycle.
- RESET overrides any simultaneous accept.

## Test plan
- After reset, hold IN_VALID = 0 for 5 cycles → WEN = 0, IN_READY = 1, PEND_VALID = 0 throughout.
- ALU write: accept rd = 5, SRC = 00, ALU = 0x1234_5678, followed by 3 back-to-back ALU writes to rd = 6, 7, 8 → WEN high for 4 consecutive cycles with matching RD_SEL/WB_DATA. The register file then reads x5 = 0x1234_5678.
- Load formatting: MEM_RDATA = 0x80FF_7F01 with rd = 10, and MEM_RVALID asserted 3 cycles after accept, checked for each load type and offset:
  - LB b = 3 → 0xFFFF_FF80
  - LBU b = 3 → 0x0000_0080
  - LH ADDR[1] = 0 → 0x0000_7F01
  - LH ADDR[1] = 1 → 0xFFFF_80FF
  - LHU ADDR[1] = 1 → 0x0000_80FF
  - LW → 0x80FF_7F01
  - In every case IN_READY = 0 and PEND_VALID = 1 with PEND_RD_SEL = 10 during the wait.
- x0 and no-write: accept rd = 0 with ALU = 0xDEAD_BEEF, and separately rd = 3 with IN_WEN = 0 → WEN never asserts. An MEM_RVALID pulse while IDLE causes no state change.
- JAL link: accept SRC = 10, PC+4 = 0x0000_0104, rd = 1 → the next cycle has WEN = 1, RD_SEL = 1, WB_DATA = 0x0000_0104.
- Reset mid-load: accept an LW to rd = 4, then assert RESET in WAIT_MEM together with MEM_RVALID = 1 → WEN stays 0, the next cycle is IDLE with IN_READY = 1, and x4 is unchanged.
